// File: rtl/prelude_pkg.sv
// Shared types for the Prelude execution controller: sequencer states and halt causes.
package prelude_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    HALT = 2'b01,
    RUN  = 2'b10,
    STEP = 2'b11
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_RESET = 2'b00,
    CAUSE_CMD   = 2'b01,
    CAUSE_BREAK = 2'b10,
    CAUSE_STEP  = 2'b11
  } halt_cause_t;

endpackage

// File: rtl/prelude_tick_div.sv
// Instruction-rate prescaler: tick once every div_limit+1 enabled cycles.
module prelude_tick_div #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_limit,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_count;

  // >= rather than == so a lowered limit never waits for wrap-around.
  assign tick = enable && (r_count >= div_limit);

  // NOTE: synchronous reset lives inside the clocked branch; all state uses <=.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (enable) begin
      if (tick) r_count <= '0;
      else      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/prelude_run_ctrl.sv
// Prelude CPU execution controller: reset hold, run/halt/step sequencing,
// rate-limited cpu_en strobes, PC breakpoint and retired-instruction count.
module prelude_run_ctrl
  import prelude_pkg::*;
#(
  parameter int DIV_WIDTH    = 24,
  parameter int RESET_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_run,
  input  logic                 cmd_halt,
  input  logic                 cmd_step,
  input  logic [DIV_WIDTH-1:0] div_limit,
  input  logic                 bp_enable,
  input  logic [7:0]           bp_addr,
  input  logic [7:0]           pc,
  output logic                 cpu_reset,
  output logic                 cpu_en,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [15:0]          retired
);

  localparam int              HOLD_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);

  run_state_t        r_state;
  halt_cause_t       r_cause;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_prev_run, r_prev_halt, r_prev_step;
  logic              r_skip_bp;
  logic              r_cpu_reset, r_cpu_en, r_halted;
  logic [15:0]       r_retired;

  logic w_edge_run, w_edge_halt, w_edge_step;
  logic w_tick, w_div_clear, w_div_en, w_bp_hit;

  assign w_edge_run  = cmd_run  & ~r_prev_run;
  assign w_edge_halt = cmd_halt & ~r_prev_halt;
  assign w_edge_step = cmd_step & ~r_prev_step;

  assign w_div_en    = (r_state == RUN) || (r_state == STEP);
  assign w_div_clear = (r_state == HALT) && !w_edge_halt && (w_edge_step || w_edge_run);
  assign w_bp_hit    = bp_enable && (pc == bp_addr) && !r_skip_bp;

  prelude_tick_div #(.DIV_WIDTH(DIV_WIDTH)) u_tick_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_div_clear),
    .enable    (w_div_en),
    .div_limit (div_limit),
    .tick      (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= HOLD;
      r_cause     <= CAUSE_RESET;
      r_hold_cnt  <= HOLD_LOAD;
      // Held levels must not look like fresh edges once reset drops.
      r_prev_run  <= 1'b1;
      r_prev_halt <= 1'b1;
      r_prev_step <= 1'b1;
      r_skip_bp   <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_cpu_en    <= 1'b0;
      r_halted    <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_prev_run  <= cmd_run;
      r_prev_halt <= cmd_halt;
      r_prev_step <= cmd_step;
      r_cpu_en    <= 1'b0;
      case (r_state)
        HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state     <= HALT;
            r_cause     <= CAUSE_RESET;
            r_cpu_reset <= 1'b0;
            r_halted    <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        HALT: begin
          if (w_edge_halt) begin
            r_state <= HALT;
          end else if (w_edge_step) begin
            r_state   <= STEP;
            r_halted  <= 1'b0;
            r_skip_bp <= 1'b1;
          end else if (w_edge_run) begin
            r_state   <= RUN;
            r_halted  <= 1'b0;
            r_skip_bp <= 1'b1;
          end
        end
        RUN: begin
          if (w_edge_halt) begin
            r_state  <= HALT;
            r_cause  <= CAUSE_CMD;
            r_halted <= 1'b1;
          end else if (w_tick && w_bp_hit) begin
            r_state  <= HALT;
            r_cause  <= CAUSE_BREAK;
            r_halted <= 1'b1;
          end else if (w_tick) begin
            r_cpu_en  <= 1'b1;
            r_retired <= r_retired + 16'd1;
            r_skip_bp <= 1'b0;
          end
        end
        STEP: begin
          if (w_edge_halt) begin
            r_state  <= HALT;
            r_cause  <= CAUSE_CMD;
            r_halted <= 1'b1;
          end else if (w_tick) begin
            r_cpu_en  <= 1'b1;
            r_retired <= r_retired + 16'd1;
            r_state   <= HALT;
            r_cause   <= CAUSE_STEP;
            r_halted  <= 1'b1;
          end
        end
        default: r_state <= HOLD;
      endcase
    end
  end

  assign cpu_reset  = r_cpu_reset;
  assign cpu_en     = r_cpu_en;
  assign halted     = r_halted;
  assign halt_cause = r_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_prelude_run_ctrl.sv
// Directed bench for prelude_run_ctrl with a tiny core model that advances pc on each strobe.
module tb_prelude_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_run = 1'b0, cmd_halt = 1'b0, cmd_step = 1'b0;
  logic [23:0] div_limit = '0;
  logic        bp_enable = 1'b0;
  logic [7:0]  bp_addr = '0;
  logic [7:0]  pc_core = '0;
  logic        cpu_reset, cpu_en, halted;
  logic [1:0]  halt_cause;
  logic [15:0] retired;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prelude_run_ctrl #(.DIV_WIDTH(24), .RESET_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_run    (cmd_run),
    .cmd_halt   (cmd_halt),
    .cmd_step   (cmd_step),
    .div_limit  (div_limit),
    .bp_enable  (bp_enable),
    .bp_addr    (bp_addr),
    .pc         (pc_core),
    .cpu_reset  (cpu_reset),
    .cpu_en     (cpu_en),
    .halted     (halted),
    .halt_cause (halt_cause),
    .retired    (retired)
  );

  // Core model commits mid-strobe, so pc already points at the next instruction
  // by the following rising edge.
  always @(negedge clk) begin
    if (cpu_reset)   pc_core <= 8'd0;
    else if (cpu_en) pc_core <= pc_core + 8'd1;
  end

  task automatic pulse(input logic r, input logic s, input logic h);
    cmd_run = r; cmd_step = s; cmd_halt = h;
    @(negedge clk);
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
  endtask

  task automatic expect_hold_release();
    int n = 0;
    reset = 1'b0;
    while (cpu_reset && n < 20) begin
      n++;
      @(negedge clk);
    end
    total++; if (n !== 4) begin bad++; $display("FAIL hold_len: got %0d want 4", n); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL hold_halted: got %b want 1", halted); end
    total++; if (halt_cause !== 2'b00) begin bad++; $display("FAIL hold_cause: got %b want 00", halt_cause); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL hold_retired: got %0d want 0", retired); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rst_cpu_en: got %b want 0", cpu_en); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    total++; if (halt_cause !== 2'b00) begin bad++; $display("FAIL rst_cause: got %b want 00", halt_cause); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL rst_retired: got %0d want 0", retired); end
    expect_hold_release();
  endtask

  task automatic test_breakpoint();
    int n = 0;
    int c = 0;
    bp_enable = 1'b1; bp_addr = 8'h04; div_limit = '0;
    pulse(1'b1, 1'b0, 1'b0);
    while (!halted && c < 20) begin
      @(negedge clk);
      c++;
      if (cpu_en) n++;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL bp_strobes: got %0d want 4", n); end
    total++; if (halt_cause !== 2'b10) begin bad++; $display("FAIL bp_cause: got %b want 10", halt_cause); end
    total++; if (pc_core !== 8'h04) begin bad++; $display("FAIL bp_pc: got %0h want 04", pc_core); end
    total++; if (retired !== 16'd4) begin bad++; $display("FAIL bp_retired: got %0d want 4", retired); end
    // Resume from the breakpoint address: one strobe at 0x04, then halt on a tick.
    pulse(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL bp_resume_en: got %b want 1", cpu_en); end
    total++; if (pc_core !== 8'h04) begin bad++; $display("FAIL bp_resume_pc: got %0h want 04", pc_core); end
    cmd_halt = 1'b1;
    @(negedge clk);
    cmd_halt = 1'b0;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL bp_halt_en: got %b want 0", cpu_en); end
    total++; if (halt_cause !== 2'b01) begin bad++; $display("FAIL bp_halt_cause: got %b want 01", halt_cause); end
    total++; if (retired !== 16'd5) begin bad++; $display("FAIL bp_halt_retired: got %0d want 5", retired); end
  endtask

  task automatic test_step();
    logic [15:0] exp_ret [3] = '{16'd6, 16'd7, 16'd8};
    bp_addr = 8'h06; div_limit = 24'd1;
    for (int p = 0; p < 3; p++) begin
      int n = 0;
      pulse(1'b0, 1'b1, 1'b0);
      repeat (9) begin
        @(negedge clk);
        if (cpu_en) n++;
      end
      total++; if (n !== 1) begin bad++; $display("FAIL step%0d_strobes: got %0d want 1", p, n); end
      total++; if (halt_cause !== 2'b11) begin bad++; $display("FAIL step%0d_cause: got %b want 11", p, halt_cause); end
      total++; if (retired !== exp_ret[p]) begin bad++; $display("FAIL step%0d_retired: got %0d want %0d", p, retired, exp_ret[p]); end
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    div_limit = '0;
    pulse(1'b1, 1'b1, 1'b0);
    repeat (8) begin
      @(negedge clk);
      if (cpu_en) n++;
    end
    total++; if (n !== 1) begin bad++; $display("FAIL sim_step_run_strobes: got %0d want 1", n); end
    total++; if (halt_cause !== 2'b11) begin bad++; $display("FAIL sim_step_run_cause: got %b want 11", halt_cause); end
    total++; if (retired !== 16'd9) begin bad++; $display("FAIL sim_step_run_retired: got %0d want 9", retired); end
    // Halt outranks step in HALT, so nothing happens.
    n = 0;
    pulse(1'b0, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      if (cpu_en) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL sim_halt_step_strobes: got %0d want 0", n); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL sim_halt_step_halted: got %b want 1", halted); end
    total++; if (halt_cause !== 2'b11) begin bad++; $display("FAIL sim_halt_step_cause: got %b want 11", halt_cause); end
  endtask

  task automatic test_run_rate();
    bp_enable = 1'b0; div_limit = 24'd2;
    pulse(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      logic exp_en;
      @(negedge clk);
      exp_en = (c % 3 == 0);
      total++; if (cpu_en !== exp_en) begin bad++; $display("FAIL rate_c%0d: got %b want %b", c, cpu_en, exp_en); end
    end
    cmd_halt = 1'b1;
    @(negedge clk);
    cmd_halt = 1'b0;
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL rate_halt_en: got %b want 0", cpu_en); end
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL rate_halted: got %b want 1", halted); end
    total++; if (halt_cause !== 2'b01) begin bad++; $display("FAIL rate_cause: got %b want 01", halt_cause); end
    total++; if (retired !== 16'd14) begin bad++; $display("FAIL rate_retired: got %0d want 14", retired); end
  endtask

  task automatic test_reset_mid_run();
    div_limit = '0;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (cpu_en !== 1'b1) begin bad++; $display("FAIL mid_running: got %b want 1", cpu_en); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (cpu_en !== 1'b0) begin bad++; $display("FAIL mid_rst_en: got %b want 0", cpu_en); end
    total++; if (cpu_reset !== 1'b1) begin bad++; $display("FAIL mid_rst_cpu_reset: got %b want 1", cpu_reset); end
    total++; if (retired !== 16'd0) begin bad++; $display("FAIL mid_rst_retired: got %0d want 0", retired); end
    @(negedge clk);
    expect_hold_release();
  endtask

  task automatic test_wrap();
    int n = 0;
    int c = 0;
    bit done = 0;
    div_limit = '0;
    pulse(1'b1, 1'b0, 1'b0);
    while (!done && c < 70000) begin
      @(negedge clk);
      c++;
      if (cpu_en) begin
        n++;
        if (n == 65535) begin
          total++; if (retired !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %0h want ffff", retired); end
        end else if (n == 65536) begin
          total++; if (retired !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %0h want 0", retired); end
          done = 1;
        end
      end
    end
    total++; if (!done) begin bad++; $display("FAIL wrap_timeout: got %0d strobes want 65536", n); end
    pulse(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_breakpoint();
    test_step();
    test_simultaneous();
    test_run_rate();
    test_reset_mid_run();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
